// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared writeback encodings: result-select codes, load funct3 codes, stage states
package riscv_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] WB_SEL_IMMU = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOAD = 2'd1,
        DRAIN     = 2'd2
    } wb_state_t;

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - byte/half/word lane extraction with sign or zero extension for loads
module load_extract
    import riscv_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] data,
    output logic        illegal
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    assign lane_byte = word[8*offset +: 8];
    assign lane_half = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        data    = '0;
        illegal = 1'b0;
        case (funct3)
            F3_LB:   data = {{24{lane_byte[7]}}, lane_byte};
            F3_LBU:  data = {24'h0, lane_byte};
            F3_LH:   data = {{16{lane_half[15]}}, lane_half};
            F3_LHU:  data = {16'h0, lane_half};
            F3_LW:   data = word;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - writeback stage with load wait/timeout/drain; optional WB_RETIRE_CNT_EN retire counter
module writeback_stage
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inValid,
    output logic        inReady,
    input  logic        flush,
    input  logic [4:0]  rdAddr,
    input  logic        regWriteIn,
    input  logic [1:0]  wbSel,
    input  logic [31:0] aluResult,
    input  logic [31:0] pcPlus4,
    input  logic [31:0] immU,
    input  logic [2:0]  loadFunct3,
    input  logic [1:0]  byteOffset,
    input  logic        memRespValid,
    input  logic [31:0] memRespData,
`ifdef WB_RETIRE_CNT_EN
    output logic [63:0] instret,
`endif
    output logic        regWrite,
    output logic [4:0]  writeRegister,
    output logic [31:0] writeData,
    output logic        illegalLoad,
    output logic        loadTimeout
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    wb_state_t   state, state_nxt;
    logic [7:0]  wait_cnt, wait_cnt_nxt;

    logic [4:0]  ld_rd;
    logic        ld_we;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_offset;

    logic        accept;
    logic        capture;
    logic        out_load;
    logic        out_we;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        out_illegal;
    logic        out_timeout;
    logic [31:0] sel_result;
    logic [31:0] ext_data;
    logic        ext_illegal;
`ifdef WB_RETIRE_CNT_EN
    logic        retire;
`endif

    load_extract u_load_extract (
        .word    (memRespData),
        .funct3  (ld_funct3),
        .offset  (ld_offset),
        .data    (ext_data),
        .illegal (ext_illegal)
    );

    assign inReady = (state == IDLE);
    assign accept  = inValid && inReady && !flush;

    always_comb begin
        case (wbSel)
            WB_SEL_PC4:  sel_result = pcPlus4;
            WB_SEL_IMMU: sel_result = immU;
            default:     sel_result = aluResult;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        capture      = 1'b0;
        out_load     = 1'b0;
        out_we       = 1'b0;
        out_rd       = rdAddr;
        out_data     = sel_result;
        out_illegal  = 1'b0;
        out_timeout  = 1'b0;
`ifdef WB_RETIRE_CNT_EN
        retire       = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    if (wbSel == WB_SEL_LOAD) begin
                        capture      = 1'b1;
                        wait_cnt_nxt = '0;
                        state_nxt    = WAIT_LOAD;
                    end else begin
                        out_load = 1'b1;
                        out_we   = regWriteIn && (rdAddr != 5'd0);
`ifdef WB_RETIRE_CNT_EN
                        retire   = 1'b1;
`endif
                    end
                end
            end
            WAIT_LOAD: begin
                // Flush beats a same-cycle response; only a pending response needs draining
                if (flush) begin
                    wait_cnt_nxt = '0;
                    state_nxt    = memRespValid ? IDLE : DRAIN;
                end else if (memRespValid) begin
                    state_nxt   = IDLE;
                    out_load    = 1'b1;
                    out_rd      = ld_rd;
                    out_data    = ext_data;
                    out_illegal = ext_illegal;
                    out_we      = ld_we && (ld_rd != 5'd0) && !ext_illegal;
`ifdef WB_RETIRE_CNT_EN
                    retire      = !ext_illegal;
`endif
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    wait_cnt_nxt = '0;
                    out_timeout  = 1'b1;
                    state_nxt    = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            DRAIN: begin
                if (memRespValid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            ld_rd         <= '0;
            ld_we         <= 1'b0;
            ld_funct3     <= '0;
            ld_offset     <= '0;
            regWrite      <= 1'b0;
            writeRegister <= '0;
            writeData     <= '0;
            illegalLoad   <= 1'b0;
            loadTimeout   <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            regWrite    <= out_we;
            illegalLoad <= out_illegal;
            loadTimeout <= out_timeout;
            if (capture) begin
                ld_rd     <= rdAddr;
                ld_we     <= regWriteIn;
                ld_funct3 <= loadFunct3;
                ld_offset <= byteOffset;
            end
            if (out_load) begin
                writeRegister <= out_rd;
                writeData     <= out_data;
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - randomized self-checking bench for writeback_stage against a transaction-level model
module tb_writeback_stage;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inValid, inReady, flush;
    logic [4:0]  rdAddr;
    logic        regWriteIn;
    logic [1:0]  wbSel;
    logic [31:0] aluResult, pcPlus4, immU;
    logic [2:0]  loadFunct3;
    logic [1:0]  byteOffset;
    logic        memRespValid;
    logic [31:0] memRespData;
    logic        regWrite;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic        illegalLoad, loadTimeout;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] instret;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    longint exp_instret = 0;

    always #5 clk = ~clk;

    writeback_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .inValid       (inValid),
        .inReady       (inReady),
        .flush         (flush),
        .rdAddr        (rdAddr),
        .regWriteIn    (regWriteIn),
        .wbSel         (wbSel),
        .aluResult     (aluResult),
        .pcPlus4       (pcPlus4),
        .immU          (immU),
        .loadFunct3    (loadFunct3),
        .byteOffset    (byteOffset),
        .memRespValid  (memRespValid),
        .memRespData   (memRespData),
`ifdef WB_RETIRE_CNT_EN
        .instret       (instret),
`endif
        .regWrite      (regWrite),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .illegalLoad   (illegalLoad),
        .loadTimeout   (loadTimeout)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference load semantics from byte arithmetic on the response word
    task automatic ref_load(input int f3, input int off, input logic [31:0] w,
                            output logic [31:0] d, output bit ill);
        int unsigned b, h;
        b   = (w >> (8 * off)) & 32'hFF;
        h   = (w >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
        ill = 0;
        d   = 0;
        case (f3)
            0: d = (b >= 128) ? 32'(int'(b) - 256) : b;
            4: d = b;
            1: d = (h >= 32768) ? 32'(int'(h) - 65536) : h;
            5: d = h;
            2: d = w;
            default: ill = 1;
        endcase
    endtask

    task automatic junk_inputs();
        rdAddr      = 5'($urandom);
        regWriteIn  = 1'($urandom);
        wbSel       = 2'($urandom);
        aluResult   = $urandom;
        pcPlus4     = $urandom;
        immU        = $urandom;
        loadFunct3  = 3'($urandom);
        byteOffset  = 2'($urandom);
        memRespData = $urandom;
    endtask

    task automatic issue(input int sel, input int rd, input bit we, input int f3, input int off,
                         input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] imm);
        check("in_ready_idle", inReady, 1);
        inValid = 1; flush = 0; memRespValid = 0;
        wbSel = 2'(sel); rdAddr = 5'(rd); regWriteIn = we;
        loadFunct3 = 3'(f3); byteOffset = 2'(off);
        aluResult = alu; pcPlus4 = pc4; immU = imm;
        @(posedge clk);
        @(negedge clk);
        inValid = 0;
        junk_inputs();
    endtask

    task automatic run_alu(input int sel, input int rd, input bit we,
                           input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] imm);
        logic [31:0] expd;
        expd = (sel == 2) ? pc4 : (sel == 3) ? imm : alu;
        issue(sel, rd, we, 0, 0, alu, pc4, imm);
        exp_instret++;
        check("alu_reg_write", regWrite, (we && rd != 0));
        check("alu_write_reg", writeRegister, rd);
        check("alu_write_data", writeData, expd);
        @(negedge clk);
        check("alu_one_cycle", regWrite, 0);
    endtask

    // d: wait cycle carrying the response; fc: wait cycle carrying flush (-1 none)
    task automatic run_load(input int f3, input int off, input int rd, input bit we,
                            input logic [31:0] w, input int d, input int fc);
        logic [31:0] expd;
        bit ill;
        ref_load(f3, off, w, expd, ill);
        issue(1, rd, we, f3, off, $urandom, $urandom, $urandom);
        for (int i = 0; i < T + 8; i++) begin
            check("in_ready_wait", inReady, 0);
            check("no_early_write", regWrite, 0);
            flush        = (i == fc);
            memRespValid = (i == d);
            memRespData  = (i == d) ? w : $urandom;
            @(posedge clk);
            @(negedge clk);
            flush = 0; memRespValid = 0;
            if (i == fc) begin
                if (d > i) begin
                    for (int j = i + 1; j <= d; j++) begin
                        check("in_ready_drain", inReady, 0);
                        check("drain_no_timeout", loadTimeout, 0);
                        memRespValid = (j == d);
                        memRespData  = w;
                        @(posedge clk);
                        @(negedge clk);
                        memRespValid = 0;
                    end
                end
                check("flush_no_write", regWrite, 0);
                check("flush_idle", inReady, 1);
                return;
            end
            if (i == d && d < T) begin
                if (!ill) exp_instret++;
                check("ld_reg_write", regWrite, (we && rd != 0 && !ill));
                check("ld_illegal", illegalLoad, ill);
                check("ld_write_reg", writeRegister, rd);
                if (!ill) check("ld_write_data", writeData, expd);
                @(negedge clk);
                check("ld_one_cycle", regWrite | illegalLoad, 0);
                return;
            end
            if (i == T - 1) begin
                check("timeout_pulse", loadTimeout, 1);
                check("timeout_no_write", regWrite, 0);
                check("timeout_idle", inReady, 1);
                @(negedge clk);
                check("timeout_one_cycle", loadTimeout, 0);
                return;
            end
            check("timeout_early", loadTimeout, 0);
        end
        check("load_bound_expired", 1, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sel, d, fc, f3;
        rst_n = 0; inValid = 0; flush = 0; memRespValid = 0;
        junk_inputs();
        @(negedge clk);
        check("rst_reg_write", regWrite, 0);
        check("rst_write_reg", writeRegister, 0);
        check("rst_write_data", writeData, 0);
        check("rst_in_ready", inReady, 1);
        check("rst_flags", {illegalLoad, loadTimeout}, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        run_alu(0, 5, 1, 32'h0000_1234, 32'h0, 32'h0);
        run_load(0, 3, 7, 1, 32'h80FF_FFFF, 2, -1);
        run_load(5, 2, 9, 1, 32'hBEEF_0000, 1, -1);
        run_alu(0, 0, 1, 32'hCAFE_0001, 32'h0, 32'h0);
        run_load(2, 0, 3, 1, 32'hDEAD_BEEF, 3, 0);
        run_load(2, 0, 4, 1, 32'h1111_2222, 5, 5);
        run_load(2, 0, 6, 1, 32'h0, T + 20, -1);
        run_load(3, 0, 8, 1, 32'h1234_5678, 0, -1);
        run_load(1, 2, 10, 1, 32'h8001_7FFF, T - 1, -1);

        // stray response and flushed request while idle
        memRespValid = 1; memRespData = 32'hFFFF_FFFF;
        @(posedge clk); @(negedge clk);
        memRespValid = 0;
        check("idle_resp_ignored", regWrite, 0);
        check("idle_resp_ready", inReady, 1);
        inValid = 1; flush = 1; wbSel = 2'b01; rdAddr = 5'd1; regWriteIn = 1;
        @(posedge clk); @(negedge clk);
        inValid = 0; flush = 0;
        check("flush_blocks_accept", inReady, 1);
        check("flush_blocks_write", regWrite, 0);

        // reset mid-load
        run_alu(2, 12, 1, 32'h0, 32'h0000_0104, 32'h0);
        issue(1, 13, 1, 2, 0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 0;
        #1;
        check("rst_mid_reg_write", regWrite, 0);
        check("rst_mid_write_reg", writeRegister, 0);
        check("rst_mid_write_data", writeData, 0);
        check("rst_mid_idle", inReady, 1);
        exp_instret = 0;
        @(negedge clk);
        rst_n = 1;
        memRespValid = 1; memRespData = 32'h5555_AAAA;
        @(posedge clk); @(negedge clk);
        memRespValid = 0;
        check("rst_no_late_write", regWrite, 0);
        check("rst_no_late_data", writeData, 0);

        for (int k = 0; k < 60; k++) begin
            sel = $urandom_range(0, 3);
            if (sel != 1) begin
                run_alu(sel, $urandom_range(0, 31), 1'($urandom), $urandom, $urandom, $urandom);
            end else begin
                f3 = $urandom_range(0, 7);
                d  = $urandom_range(0, T + 3);
                fc = -1;
                if ($urandom_range(0, 4) == 0) fc = $urandom_range(0, (d < T) ? d : T - 1);
                run_load(f3, $urandom_range(0, 3), $urandom_range(0, 31), 1'($urandom),
                         $urandom, d, fc);
            end
        end

`ifdef WB_RETIRE_CNT_EN
        check("instret", instret, exp_instret);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
